// File: rtl/lerp_pkg.sv
// Shared widths, rounding constant and a scalar reference model for lerp_pipe.
package lerp_pkg;

  function automatic int unsigned diff_w(input int unsigned ib);
    return ib + 1;
  endfunction

  function automatic int unsigned prod_w(input int unsigned ib, input int unsigned rb);
    return ib + rb + 1;
  endfunction

  function automatic longint unsigned round_const(input int unsigned rb);
    return (rb == 0) ? 64'd0 : (64'd1 << (rb - 1));
  endfunction

  function automatic longint lerp_ref(input longint ina, input longint inb,
                                      input longint ratio, input int unsigned rb,
                                      input bit rnd);
    longint p;
    p = (ina - inb) * ratio;
    if (rnd) p = p + longint'(round_const(rb));
    return inb + (p >>> rb);
  endfunction

endpackage

// File: rtl/lerp_pipe_stage.sv
// Register slice with valid bit; on load the valid follows upstream and data captures only real beats.
module lerp_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         vin,
  input  logic [W-1:0] d,
  output logic         vout,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vout <= 1'b0;
      q    <= '0;
    end else if (load) begin
      vout <= vin;
      if (vin) q <= d;
    end
  end

endmodule

// File: rtl/lerp_pipe.sv
// Three-stage valid/ready linear interpolator: out = inb + (ina - inb) * ratio.
// Define LERP_PIPE_ROUND_EN for round-half-up instead of floor in the final stage.
module lerp_pipe
  import lerp_pkg::*;
#(
  parameter int unsigned INPUT_BITS      = 16,
  parameter int unsigned RATIO_FRAC_BITS = 8,
  parameter int unsigned TAG_BITS        = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_BITS-1:0]      ina,
  input  logic [INPUT_BITS-1:0]      inb,
  input  logic [RATIO_FRAC_BITS-1:0] ratio,
  input  logic [TAG_BITS-1:0]        in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_BITS-1:0]      out,
  output logic [TAG_BITS-1:0]        out_tag
);

  localparam int unsigned IB  = INPUT_BITS;
  localparam int unsigned RB  = RATIO_FRAC_BITS;
  localparam int unsigned TB  = TAG_BITS;
  localparam int unsigned DW  = diff_w(IB);
  localparam int unsigned PW  = prod_w(IB, RB);
  localparam int unsigned S1W = DW + IB + RB + TB;
  localparam int unsigned S2W = PW + IB + TB;
  localparam int unsigned S3W = IB + TB;

  logic s1_v, s2_v, s3_v;
  logic ld1, ld2, ld3;

  logic [S1W-1:0] s1_in, s1_q;
  logic [S2W-1:0] s2_in, s2_q;
  logic [S3W-1:0] s3_in, s3_q;

  // A stage loads when empty or when its occupant leaves this cycle, so bubbles collapse.
  always_comb begin
    ld3      = !s3_v || out_ready;
    ld2      = !s2_v || ld3;
    ld1      = !s1_v || ld2;
    in_ready = ld1;
  end

  logic [DW-1:0] d_n;
  always_comb begin
    d_n   = {1'b0, ina} - {1'b0, inb};
    s1_in = {d_n, inb, ratio, in_tag};
  end

  logic [DW-1:0]        s1_d;
  logic [IB-1:0]        s1_inb;
  logic [RB-1:0]        s1_ratio;
  logic [TB-1:0]        s1_tag;
  logic signed [PW-1:0] dx, rx, p_n;

  always_comb begin
    s1_d     = s1_q[S1W-1 -: DW];
    s1_inb   = s1_q[IB+RB+TB-1 -: IB];
    s1_ratio = s1_q[RB+TB-1 -: RB];
    s1_tag   = s1_q[TB-1:0];
    dx       = PW'(signed'(s1_d));
    rx       = PW'({1'b0, s1_ratio});
    p_n      = dx * rx;
    s2_in    = {p_n, s1_inb, s1_tag};
  end

  logic signed [PW-1:0] s2_p, c_n;
  logic [IB-1:0]        s2_inb, out_n;
  logic [TB-1:0]        s2_tag;

`ifdef LERP_PIPE_ROUND_EN
  localparam logic signed [PW-1:0] RC = PW'(round_const(RB));
  logic signed [PW-1:0] pr;
  always_comb begin
    pr  = s2_p + RC;
    c_n = pr >>> RB;
  end
`else
  always_comb c_n = s2_p >>> RB;
`endif

  always_comb begin
    s2_p   = s2_q[S2W-1 -: PW];
    s2_inb = s2_q[IB+TB-1 -: IB];
    s2_tag = s2_q[TB-1:0];
    out_n  = IB'(c_n) + s2_inb;
    s3_in  = {out_n, s2_tag};
  end

  always_comb begin
    out_valid = s3_v;
    out       = s3_q[S3W-1 -: IB];
    out_tag   = s3_q[TB-1:0];
  end

  lerp_pipe_stage #(.W(S1W)) u_s1 (
    .clk(clk), .reset_n(reset_n), .load(ld1), .vin(in_valid),
    .d(s1_in), .vout(s1_v), .q(s1_q)
  );

  lerp_pipe_stage #(.W(S2W)) u_s2 (
    .clk(clk), .reset_n(reset_n), .load(ld2), .vin(s1_v),
    .d(s2_in), .vout(s2_v), .q(s2_q)
  );

  lerp_pipe_stage #(.W(S3W)) u_s3 (
    .clk(clk), .reset_n(reset_n), .load(ld3), .vin(s2_v),
    .d(s3_in), .vout(s3_v), .q(s3_q)
  );

endmodule

// File: tb/tb_lerp_pipe.sv
// Self-checking bench for lerp_pipe: vector table, directed handshake sequences, random streaming.
module tb_lerp_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] ina, inb, out;
  logic [7:0]  ratio;
  logic [3:0]  in_tag, out_tag;

  always #5 clk = ~clk;

  lerp_pipe #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8), .TAG_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .ratio(ratio), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag)
  );

  int checks   = 0;
  int failures = 0;
  int ndeq     = 0;

  typedef struct { logic [15:0] o; logic [3:0] t; } exp_t;
  exp_t q[$];

  typedef struct {
    logic [15:0] a, b;
    logic [7:0]  r;
    logic [15:0] ex_floor, ex_round;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // interpolation as real-valued fraction, floored (or rounded half up)
  function automatic logic [15:0] mdl(input int a, input int b, input int r);
    longint num, qv;
    num = longint'(a - b) * r;
`ifdef LERP_PIPE_ROUND_EN
    num = num + 128;
`endif
    qv = num / 256;
    if (num < 0 && (num % 256) != 0) qv = qv - 1;
    return 16'(b + qv);
  endfunction

  // Inputs applied at posedge+1, handshakes evaluated at posedge+4.
  task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic [7:0] r, input logic [3:0] t, input logic ordy,
                     input logic [15:0] ex, output logic acc);
    exp_t e;
    in_valid = v; ina = a; inb = b; ratio = r; in_tag = t; out_ready = ordy;
    #3;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      ndeq++;
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_out: got out=%0h tag=%0h expected no beat", out, out_tag);
      end else begin
        e = q.pop_front();
        chk("out", out, e.o);
        chk("out_tag", out_tag, e.t);
      end
    end
    if (acc) q.push_back('{ex, t});
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] r,
                      input logic [3:0] t, input logic [15:0] ex);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cyc(1'b1, a, b, r, t, 1'b1, ex, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cyc(1'b0, 16'h0, 16'h0, 8'h0, 4'h0, ordy, 16'h0, acc);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) idle(1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, rdy;
    logic [15:0] a, b, ex, hold_o;
    logic [7:0]  r;
    logic [3:0]  hold_t;
    int          k, start, cnt, c;
    logic        pat[4];

    vecs[0] = '{16'h1000, 16'h0000, 8'h80, 16'h0800, 16'h0800};
    vecs[1] = '{16'h0000, 16'h1000, 8'h80, 16'h0800, 16'h0800};
    vecs[2] = '{16'hBEEF, 16'h1234, 8'h00, 16'h1234, 16'h1234};
    vecs[3] = '{16'h0003, 16'h0000, 8'h80, 16'h0001, 16'h0002};
    vecs[4] = '{16'h0000, 16'h0003, 8'h80, 16'h0001, 16'h0002};
    vecs[5] = '{16'hFFFF, 16'h0000, 8'hFF, 16'hFEFF, 16'hFEFF};
    vecs[6] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h00FF, 16'h0100};
    vecs[7] = '{16'hABCD, 16'hABCD, 8'h5A, 16'hABCD, 16'hABCD};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ina = '0; inb = '0; ratio = '0; in_tag = '0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // latency: accepted beat shows up three edges later
    @(posedge clk); #1;
    cyc(1'b1, 16'h1000, 16'h0000, 8'h80, 4'h5, 1'b0, 16'h0800, acc);
    chk("lat_accept", acc, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("latency", k, 3);
    drain();

    for (int i = 0; i < 8; i++) begin
`ifdef LERP_PIPE_ROUND_EN
      ex = vecs[i].ex_round;
`else
      ex = vecs[i].ex_floor;
`endif
      send(vecs[i].a, vecs[i].b, vecs[i].r, 4'(i), ex);
    end
    drain();

    // out_ready toggling 1,0,0,1 while streaming tags 0..9
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    start = ndeq; c = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); r = 8'($urandom);
      acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) begin
        cyc(1'b1, a, b, r, 4'(i), pat[c % 4], mdl(int'(a), int'(b), int'(r)), acc);
        c++;
      end
      chk("bp_accept", acc, 1'b1);
    end
    drain();
    chk("bp_count", ndeq - start, 10);

    // stall: three beats fill the pipe, fourth is refused
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); r = 8'($urandom);
      cyc(1'b1, a, b, r, 4'(i + 3), 1'b0, mdl(int'(a), int'(b), int'(r)), acc);
      if (acc) cnt++;
    end
    chk("stall_count", cnt, 3);
    chk("stall_in_ready", in_ready, 1'b0);
    hold_o = out; hold_t = out_tag;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_out", out, hold_o);
      chk("stall_tag", out_tag, hold_t);
    end
    // full pipe with downstream ready: accept and emit in the same cycle
    in_valid = 1'b1; out_ready = 1'b1; #1;
    rdy = in_ready;
    chk("full_passthru_ready", rdy, 1'b1);
    a = 16'($urandom); b = 16'($urandom); r = 8'($urandom);
    cyc(1'b1, a, b, r, 4'hE, 1'b1, mdl(int'(a), int'(b), int'(r)), acc);
    chk("full_passthru_acc", acc, 1'b1);
    drain();

    // throughput: 100 back-to-back beats
    start = ndeq;
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom); b = 16'($urandom); r = 8'($urandom);
      if (i % 10 == 0) r = 8'h00;
      if (i % 10 == 1) b = a;
      if (i % 10 == 2) begin r = 8'hFF; b = 16'h0; end
      cyc(1'b1, a, b, r, 4'($urandom), 1'b1, mdl(int'(a), int'(b), int'(r)), acc);
      chk("tp_accept", acc, 1'b1);
    end
    chk("throughput", ndeq - start, 97);
    drain();

    // asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); r = 8'($urandom);
      cyc(1'b1, a, b, r, 4'(i + 1), 1'b0, mdl(int'(a), int'(b), int'(r)), acc);
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_out", out, 16'h0);
    chk("mid_rst_tag", out_tag, 4'h0);
    q.delete();
    #10 reset_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_valid_after", out_valid, 1'b0);
    @(posedge clk); #1;
    start = ndeq;
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("no_stale", ndeq - start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lerp_pipe.md
Name: lerp_pipe

Overview:
- Pipelined, back-pressurable linear interpolator: out = inb + (ina − inb)·ratio, with ratio an unsigned fraction in [0, 1).
- Successor to the combinational interpolator. Generalised width, ratio precision and sideband tag, plus a valid/ready handshake and optional round-to-nearest.
- Sits between the wavetable/envelope fetch and the voice mixer.
- The tag (voice/channel index) travels alongside each sample so interleaved voices share one instance.

Parameters:
- INPUT_BITS, 16, width of ina/inb/out (unsigned, QUx.0).
- RATIO_FRAC_BITS, 8, width of ratio (QU0.r).
- TAG_BITS, 4, width of the sideband tag carried with each sample (≥1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts input this cycle.
- ina  input  INPUT_BITS  endpoint selected at ratio→1.
- inb  input  INPUT_BITS  endpoint selected at ratio=0.
- ratio  input  RATIO_FRAC_BITS  interpolation fraction.
- in_tag  input  TAG_BITS  sideband, passed unmodified.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out  output  INPUT_BITS  interpolated result.
- out_tag  output  TAG_BITS  tag of the beat on out.

Behaviour:
- Transfer occurs when valid && ready, on either side. A beat accepted on cycle N appears on out at the earliest on cycle N+3 (3 register stages).
- Stage S1 registers:
  - d = {0,ina} − {0,inb}, signed INPUT_BITS+1 bits;
  - inb;
  - ratio;
  - tag.
- Stage S2 registers:
  - p = d · {0,ratio}, signed INPUT_BITS+RATIO_FRAC_BITS+1 bits, exact, no overflow;
  - inb;
  - tag.
- Stage S3 registers:
  - c = p >>> RATIO_FRAC_BITS (arithmetic shift, i.e. floor);
  - out = (c + inb) truncated to INPUT_BITS;
  - tag.
  - The result is always within [min(ina,inb), max(ina,inb)], so truncation never loses information.
- Flow control:
  - Each stage holds a valid bit.
  - Stage k loads when it is empty or its contents move forward this cycle. Bubbles collapse.
  - S3 moves when out_ready=1.
  - in_ready = !s1_valid || (s1 moves). This path is combinational from out_ready through the stage valids. No combinational path from in_valid to in_ready.
  - Data registers of a stage hold their value while the stage is stalled.
  - out, out_tag and out_valid are stable while out_valid && !out_ready.
- Throughput is one beat per cycle when out_ready is held at 1.
- Boundary values:
  - ratio=0 gives out=inb exactly.
  - ina=inb gives out=inb for any ratio.
  - ratio=all-ones and inb=0 gives out = floor(ina·(2^r−1)/2^r).
- Full pipeline with out_ready=0: in_ready=0, nothing is lost or duplicated.
- Simultaneous out transfer and in accept with a full pipeline: all stages advance, in_ready=1.
- Reset:
  - reset_n=0 immediately clears all stage valids, so out_valid=0 and in_ready=1 after release.
  - Data registers reset to 0, so out=0 and out_tag=0.
  - Reset mid-stream discards in-flight beats. No partial beat emerges after release.

Optional Feature:
- Macro LERP_PIPE_ROUND_EN.
- Defined: S3 computes c = (p + 2^(RATIO_FRAC_BITS−1)) >>> RATIO_FRAC_BITS, i.e. round-half-up toward +∞. The result stays within [min,max] of the endpoints.
- Undefined: floor, exactly as in Behaviour.
- Latency and handshake are identical in both builds.

Decomposition:
- Package lerp_pkg holds:
  - typedef templates/widths as localparam functions of the parameters (diff width INPUT_BITS+1, product width INPUT_BITS+RATIO_FRAC_BITS+1);
  - the rounding-constant function;
  - a reference model function lerp_ref(ina,inb,ratio,round) for the bench.
- One sub-module is natural: lerp_pipe_stage. It is a parametrised-width register slice with valid, load-enable and async active-low reset, instantiated three times.

Test Plan:
- Defaults, no round, out_ready=1. (ina=0x1000,inb=0,ratio=0x80) → out=0x0800 on cycle+3. (ina=0,inb=0x1000,ratio=0x80) → 0x0800. ratio=0x00 with any ina, inb=0x1234 → 0x1234.
- Sign/round:
  - (ina=3,inb=0,ratio=0x80) → 1 without LERP_PIPE_ROUND_EN, 2 with it.
  - (ina=0,inb=3,ratio=0x80) → 1 without, 2 with.
- Extremes: (ina=0xFFFF,inb=0,ratio=0xFF) → 0xFEFF. (ina=0,inb=0xFFFF,ratio=0xFF) → 0x00FF. Neither wraps.
- Backpressure: stream 10 beats with tags 0..9 while out_ready toggles 1,0,0,1 pattern. Outputs appear in order with matching tags, none dropped or duplicated. With out_ready=0 and 3 beats held, in_ready=0 and out is stable.
- Throughput: 100 random beats, in_valid=out_ready=1. One result per cycle after 3-cycle fill. All outputs match lerp_ref.
- Reset mid-stream: assert reset_n=0 with 3 beats in flight, asynchronously, off-edge. out_valid drops immediately and out=0. After release in_ready=1 and no stale beat is emitted.
